// File: rtl/spike_readout_accum.sv
// spike_readout_accum: counts spikes per neuron over a programmable window,
// then scans the counters once to report the most active neuron (argmax),
// its count, whether another neuron tied it, and the total spikes seen.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Valid must not depend combinationally on ready. Both
// spike_ready and result_valid come straight from flops.
module spike_readout_accum #(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid,
  input  logic [NEURON_ID_W-1:0] spike_id,
  output logic                   spike_ready,
  input  logic                   win_start,
  input  logic [15:0]            win_len,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [NEURON_ID_W-1:0] result_id,
  output logic [CNT_W-1:0]       result_count,
  output logic                   result_tie,
  output logic [15:0]            total_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCAN  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [NEURON_ID_W-1:0] LAST_IDX = NEURON_ID_W'(NUM_NEURONS - 1);

  state_e                   state_q;
  logic                     spike_ready_q;
  logic                     busy_q;
  logic                     result_valid_q;
  logic [NEURON_ID_W-1:0]   result_id_q;
  logic [CNT_W-1:0]         result_count_q;
  logic                     result_tie_q;
  logic [15:0]              total_q;
  logic [15:0]              cyc_q;
  logic [NEURON_ID_W-1:0]   scan_idx_q;
  logic [CNT_W-1:0]         cnt_q [NUM_NEURONS];

  logic [15:0]              win_len_eff;
  logic                     spike_fire;
  logic                     id_in_range;
  logic [CNT_W-1:0]         sel_cnt;
  logic [CNT_W-1:0]         cnt_d;
  logic [15:0]              total_d;
  logic [15:0]              cyc_d;
  logic [CNT_W-1:0]         scan_cnt;

  // Derived values: effective window length, spike acceptance and the
  // saturating next values of the addressed counter and the total.
  always_comb begin
    win_len_eff = (win_len == 16'd0) ? 16'd1 : win_len;
    spike_fire  = spike_valid && spike_ready_q;
    id_in_range = (32'(spike_id) < 32'(NUM_NEURONS));
    sel_cnt     = cnt_q[spike_id];
    cnt_d       = (sel_cnt == {CNT_W{1'b1}}) ? sel_cnt : sel_cnt + CNT_W'(1);
    total_d     = (total_q == 16'hFFFF) ? total_q : total_q + 16'd1;
    cyc_d       = cyc_q - 16'd1;
    scan_cnt    = cnt_q[scan_idx_q];
  end

  // Control FSM plus all datapath registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      spike_ready_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_count_q <= '0;
      result_tie_q   <= 1'b0;
      total_q        <= '0;
      cyc_q          <= '0;
      scan_idx_q     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_start) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
            total_q        <= '0;
            result_id_q    <= '0;
            result_count_q <= '0;
            result_tie_q   <= 1'b0;
            cyc_q          <= win_len_eff;
            spike_ready_q  <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (spike_fire) begin
            total_q <= total_d;
            // Out-of-range ids are consumed but only count toward the total.
            if (id_in_range) cnt_q[spike_id] <= cnt_d;
          end
          cyc_q <= cyc_d;
          if (cyc_q == 16'd1) begin
            spike_ready_q <= 1'b0;
            scan_idx_q    <= '0;
            state_q       <= S_SCAN;
          end
        end

        S_SCAN: begin
          // Index 0 seeds the running max; afterwards only a strictly larger
          // count moves the winner, so the lowest index wins ties.
          if (scan_idx_q == '0 || scan_cnt > result_count_q) begin
            result_id_q    <= scan_idx_q;
            result_count_q <= scan_cnt;
            result_tie_q   <= 1'b0;
          end else if (scan_cnt == result_count_q) begin
            result_tie_q <= 1'b1;
          end
          if (scan_idx_q == LAST_IDX) begin
            result_valid_q <= 1'b1;
            state_q        <= S_HOLD;
          end else begin
            scan_idx_q <= scan_idx_q + NEURON_ID_W'(1);
          end
        end

        S_HOLD: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spike_ready  = spike_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
  assign result_count = result_count_q;
  assign result_tie   = result_tie_q;
  assign total_count  = total_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spike_readout_accum.sv
// Bench for spike_readout_accum: a driver issues windows of spikes, a
// reference model computes the argmax result from the raw per-neuron counts
// and pushes it (with its expected arrival cycle) into queues; a monitor on
// the falling edge compares every cycle the DUT presents a result.
module tb_spike_readout_accum;
  localparam int NN    = 16;
  localparam int IDW   = 4;
  localparam int CW    = 8;
  localparam int EXP_W = IDW + CW + 1 + 16;

  logic           clk;
  logic           rst;
  logic           spike_valid;
  logic [IDW-1:0] spike_id;
  logic           spike_ready;
  logic           win_start;
  logic [15:0]    win_len;
  logic           busy;
  logic           result_valid;
  logic           result_ready;
  logic [IDW-1:0] result_id;
  logic [CW-1:0]  result_count;
  logic           result_tie;
  logic [15:0]    total_count;
  logic [1:0]     dbg_state;

  int checks  = 0;
  int errors  = 0;
  int neg_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];
  int exp_cyc_q[$];
  logic prev_valid = 1'b0;

  int model_cnt[NN];
  int model_total;
  int pat_q[$];
  int pat_mode;

  spike_readout_accum #(.NUM_NEURONS(NN), .NEURON_ID_W(IDW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .spike_valid  (spike_valid),
    .spike_id     (spike_id),
    .spike_ready  (spike_ready),
    .win_start    (win_start),
    .win_len      (win_len),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .result_count (result_count),
    .result_tie   (result_tie),
    .total_count  (total_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    neg_cnt = neg_cnt + 1;
    got = {result_id, result_count, result_tie, total_count};
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (result_valid) begin
        if (!prev_valid) begin
          if (exp_cyc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL latency: result_valid rose at cycle %0d with nothing expected", neg_cnt);
          end else begin
            chk("latency", neg_cnt, exp_cyc_q.pop_front());
          end
        end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result: got %0h with empty expected queue", got);
        end else begin
          chk("result", got, exp_q[0]);
          if (result_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = result_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic run_window(input int len, input int hold, input int rst_at);
    int L, t, v, id, mx, mi, nm, k;
    L = (len == 0) ? 1 : len;
    @(posedge clk); #1;
    win_start = 1'b1;
    win_len   = 16'(len);
    t = neg_cnt + 1;
    for (int i = 0; i < NN; i++) model_cnt[i] = 0;
    model_total = 0;
    @(posedge clk); #1;
    win_start = 1'b0;
    for (int c = 1; c <= L; c++) begin
      if (c == rst_at) begin
        // reset wins over a simultaneous win_start and spike
        rst = 1'b1; win_start = 1'b1; spike_valid = 1'b1; spike_id = 4'd5;
        @(posedge clk); #1;
        rst = 1'b0; win_start = 1'b0; spike_valid = 1'b0;
        @(negedge clk);
        chk("rst_spike_ready", spike_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_id", result_id, 0);
        chk("rst_result_count", result_count, 0);
        chk("rst_result_tie", result_tie, 0);
        chk("rst_total", total_count, 0);
        return;
      end
      case (pat_mode)
        0: begin
          if (c - 1 < pat_q.size() && pat_q[c-1] >= 0) begin v = 1; id = pat_q[c-1]; end
          else begin v = 0; id = 0; end
        end
        1: begin v = $urandom_range(0, 1); id = $urandom_range(0, NN - 1); end
        default: begin v = 1; id = 1; end
      endcase
      spike_valid = v[0];
      spike_id    = IDW'(id);
      if (v != 0) begin
        if (model_total < 65535) model_total++;
        if (id < NN && model_cnt[id] < 255) model_cnt[id]++;
      end
      @(negedge clk);
      chk("accum_ready", spike_ready, 1);
      @(posedge clk); #1;
    end
    // first SCAN cycle: a spike offered here must not be taken
    spike_valid = 1'b1;
    spike_id    = 4'd4;
    @(negedge clk);
    chk("scan_ready", spike_ready, 0);
    chk("scan_busy", busy, 1);
    @(posedge clk); #1;
    spike_valid = 1'b0;

    mx = 0;
    for (int i = 0; i < NN; i++) if (model_cnt[i] > mx) mx = model_cnt[i];
    mi = -1; nm = 0;
    for (int i = 0; i < NN; i++) begin
      if (model_cnt[i] == mx) begin
        nm++;
        if (mi < 0) mi = i;
      end
    end
    exp_q.push_back({IDW'(mi), CW'(mx), (nm > 1), 16'(model_total)});
    exp_cyc_q.push_back(t + L + NN + 1);

    k = 0;
    while (!result_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: result_valid=0 after %0d cycles, required 1", k);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      win_start = (h == 0);
      win_len   = 16'd2;
    end
    @(posedge clk); #1;
    win_start    = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("idle_result_valid", result_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_result_id", result_id, mi);
    chk("idle_total", total_count, model_total);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; spike_valid = 1'b0; spike_id = '0; win_start = 1'b0;
    win_len = '0; result_ready = 1'b0; pat_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_spike_ready", spike_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_result_id", result_id, 0);
    chk("reset_result_count", result_count, 0);
    chk("reset_result_tie", result_tie, 0);
    chk("reset_total", total_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    pat_mode = 0;
    pat_q = '{3, 3, 3, 5, 5};
    run_window(10, 0, 0);
    pat_q = '{2, 7, 2, 7};
    run_window(8, 1, 0);
    pat_mode = 2;
    run_window(300, 0, 0);
    pat_mode = 0;
    pat_q.delete();
    run_window(0, 5, 0);
    pat_q = '{1, 2, 3, 4};
    run_window(20, 0, 5);
    pat_q = '{9};
    run_window(6, 0, 0);
    pat_q = '{-1, -1, -1, -1, 4};
    run_window(5, 2, 0);

    pat_mode = 1;
    repeat (8) run_window($urandom_range(0, 40), $urandom_range(0, 3), 0);

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("cycle_queue_empty", exp_cyc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_readout_accum.md
SPIKE_READOUT_ACCUM -- requirements
Module: spike_readout_accum

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 16, number of neuron spike counters.
REQ-002 SHALL have parameter NEURON_ID_W, default 4, width of spike_id and result_id.
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-neuron counter and result_count.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port spike_valid, input, 1, upstream spike event valid.
REQ-007 SHALL have port spike_id, input, NEURON_ID_W, firing neuron index.
REQ-008 SHALL have port spike_ready, output, 1, ready to accept a spike event.
REQ-009 SHALL have port win_start, input, 1, pulse that opens an accumulation window.
REQ-010 SHALL have port win_len, input, 16, window length in cycles, sampled on accepted win_start.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port result_valid, output, 1, classification result valid.
REQ-013 SHALL have port result_ready, input, 1, downstream accepts the result.
REQ-014 SHALL have port result_id, output, NEURON_ID_W, winning neuron index.
REQ-015 SHALL have port result_count, output, CNT_W, spike count of the winner.
REQ-016 SHALL have port result_tie, output, 1, another neuron matched the winning count.
REQ-017 SHALL have port total_count, output, 16, spikes accepted in the window, saturating.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, SCAN, HOLD; all outputs registered.
REQ-019 IDLE: spike_ready=0, busy=0; win_start=1 SHALL clear all counters and total_count, load cycle counter with max(win_len,1), enter ACCUM next cycle.
REQ-020 win_start SHALL be ignored in ACCUM, SCAN and HOLD.
REQ-021 ACCUM: spike_ready=1 for exactly max(win_len,1) cycles; spike accepted when spike_valid&&spike_ready.
REQ-022 Accepted spike SHALL increment count[spike_id] by 1, saturating at 2^CNT_W-1, and total_count, saturating at 65535.
REQ-023 Accepted spike with spike_id >= NUM_NEURONS SHALL be consumed, counting toward total_count only.
REQ-024 Spike accepted on the final ACCUM cycle SHALL be counted; ACCUM then goes to SCAN with spike_ready=0.
REQ-025 SCAN: one counter examined per cycle, index 0 to NUM_NEURONS-1, exactly NUM_NEURONS cycles.
REQ-026 Scan rule: strictly greater count replaces the running max and clears tie; equal count sets tie; lowest index wins ties.
REQ-027 All counts zero SHALL give result_id=0, result_count=0, result_tie=1 (NUM_NEURONS>1).
REQ-028 After SCAN: enter HOLD with result_valid=1; result_* and total_count stable while in HOLD.
REQ-029 HOLD: result_valid&&result_ready SHALL return to IDLE next cycle with result_valid=0; without result_ready, remain indefinitely.
REQ-030 Latency: win_start accepted at cycle t -> ACCUM t+1..t+L, SCAN t+L+1..t+L+NUM_NEURONS, result_valid first high at t+L+NUM_NEURONS+1, where L=max(win_len,1).
REQ-031 result_* and total_count SHALL hold last values in IDLE until the next win_start clears them.

Reset
REQ-032 rst=1 at any state, mid-window included, SHALL go to IDLE next edge; spike_ready=0, busy=0, result_valid=0, result_id=0, result_count=0, result_tie=0, total_count=0, all counters 0.
REQ-033 rst SHALL take priority over win_start, spike_valid and result_ready in the same cycle.

Verification
REQ-034 win_len=10, spikes id 3,3,3,5,5 in ACCUM -> result_id=3, count=3, tie=0, total=5, result_valid at t+27.
REQ-035 win_len=8, two spikes each to id 2 and id 7 -> result_id=2, count=2, tie=1.
REQ-036 win_len=300, spike_valid held with id 1 throughout -> count saturates 255, total=300, result_id=1.
REQ-037 win_len=0, no spikes -> one ACCUM cycle, result_id=0, count=0, tie=1; result_ready low 5 cycles keeps outputs stable, win_start pulses during HOLD ignored.
REQ-038 rst asserted mid-ACCUM after 4 spikes -> next cycle IDLE, all outputs 0; new window with 1 spike to id 9 -> result_id=9, count=1, total=1.
REQ-039 Spike on last ACCUM cycle (id 4) counted; spike_valid on first SCAN cycle not accepted (spike_ready=0).
